// File: rtl/ram_copy_pkg.sv
// Shared types and helpers for the RAM block-copy engine.
package ram_copy_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // One pointer step in the copy direction; wraps naturally at the RAM depth.
  function automatic logic [DEF_ADDR_W-1:0] wrap_step(input logic [DEF_ADDR_W-1:0] ptr,
                                                      input logic                  down);
    return down ? (ptr - 1'b1) : (ptr + 1'b1);
  endfunction

endpackage

// File: rtl/ram_copy_addr_gen.sv
// Address generator for the copy engine: read/write pointers, remaining
// word count and copy direction. Loaded once per copy, stepped after each write.
module ram_copy_addr_gen
  import ram_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] rd_ptr_nxt_o,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              down_q, down_d;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] len_m1;
  logic              overlap_down;

  // Destination lands inside the source block ahead of it: copy from the top end
  // so no source word is overwritten before it is read.
  assign span         = dst_i - src_i;
  assign len_m1       = ADDR_W'(len_i) - ADDR_W'(1);
  assign overlap_down = (LEN_W'(span) < len_i) && (dst_i != src_i);

  // Next pointer/count values: load at copy setup, step after every write.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
    down_d      = down_q;
    if (load_i) begin
      down_d      = overlap_down;
      rd_ptr_d    = overlap_down ? (src_i + len_m1) : src_i;
      wr_ptr_d    = overlap_down ? (dst_i + len_m1) : dst_i;
      remaining_d = len_i;
    end else if (step_i) begin
      rd_ptr_d    = wrap_step(rd_ptr_q, down_q);
      wr_ptr_d    = wrap_step(wr_ptr_q, down_q);
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      down_q      <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
      down_q      <= down_d;
    end
  end

  // The top registers the RAM address, so it needs the pointer value the next state will use.
  assign rd_ptr_nxt_o = rd_ptr_d;
  assign wr_ptr_o     = wr_ptr_q;
  assign last_o       = (remaining_q == LEN_W'(1));

endmodule

// File: rtl/ram_copy_engine.sv
// RAM block-copy engine (memmove semantics, addresses wrap at the RAM depth).
// Owns the RAM port while busy: one read cycle and one write cycle per word.
// Optional feature macro: RAM_COPY_CHECKSUM_EN adds a running sum of the words written.
//
//   state | meaning
//   IDLE  | waiting for start; len==0 / oversize requests answered from here
//   SETUP | load pointers and pick copy direction
//   RD    | RAM address = read pointer, word captured on exit
//   WR    | RAM address = write pointer, write strobe high
//   FIN   | done pulse, then back to IDLE
module ram_copy_engine
  import ram_copy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
`ifdef RAM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              mem_load_q, mem_load_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;

  logic              accept;
  logic              len_zero;
  logic              len_bad;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              last;

  assign accept   = (state_q == ST_IDLE) && start;
  assign len_zero = (len == '0);
  assign len_bad  = (len > MAX_LEN);

  ram_copy_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (state_q == ST_SETUP),
    .step_i       (state_q == ST_WR),
    .src_i        (src_q),
    .dst_i        (dst_q),
    .len_i        (len_q),
    .rd_ptr_nxt_o (rd_ptr_nxt),
    .wr_ptr_o     (wr_ptr),
    .last_o       (last)
  );

  // FSM next-state logic; zero-length and oversize requests never leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !len_zero && !len_bad) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_RD;
      ST_RD:    state_d = ST_WR;
      ST_WR:    state_d = last ? ST_FIN : ST_RD;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next values for the request latch, captured word and registered RAM/status outputs.
  always_comb begin
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    data_d        = data_q;
    error_d       = error_q;
    mem_address_d = mem_address_q;
    done_d        = (accept && (len_zero || len_bad)) || ((state_q == ST_WR) && last);
    mem_load_d    = (state_d == ST_WR);
    if (accept) begin
      src_d   = src_addr;
      dst_d   = dst_addr;
      len_d   = len;
      error_d = len_bad;
    end
    if (state_q == ST_RD) data_d = mem_out;
    if (state_d == ST_RD)      mem_address_d = rd_ptr_nxt;
    else if (state_d == ST_WR) mem_address_d = wr_ptr;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      data_q        <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      mem_load_q    <= 1'b0;
      mem_address_q <= '0;
    end else begin
      src_q         <= src_d;
      dst_q         <= dst_d;
      len_q         <= len_d;
      data_q        <= data_d;
      done_q        <= done_d;
      error_q       <= error_d;
      mem_load_q    <= mem_load_d;
      mem_address_q <= mem_address_d;
    end
  end

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running sum of written words, restarted by every accepted request.
  always_comb begin
    checksum_d = checksum_q;
    if (accept)                 checksum_d = '0;
    else if (state_q == ST_WR)  checksum_d = checksum_q + data_q;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign mem_load    = mem_load_q;
  assign mem_address = mem_address_q;
  assign mem_in      = data_q;

endmodule
